// File: rtl/cpu_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_axi_bridge
//  Purpose  : Merges the CPU instruction and data sram-like ports onto one
//             single-beat AXI3 master (one read path, one write path).
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_axi_bridge #(
   parameter logic [3:0] INST_ID = 4'd0,
   parameter logic [3:0] DATA_ID = 4'd1
) (
   input  logic        clk,
   input  logic        reset,
   // instruction port
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   // data port
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,
   // read address channel
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   // read data channel
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   // write address channel
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   // write data channel
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   // write response channel
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_R = 2'd2} rd_state_t;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_B = 2'd2} wr_state_t;

   rd_state_t   rd_state_q, rd_state_d;
   wr_state_t   wr_state_q, wr_state_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        inst_busy_q, inst_busy_d;
   logic        data_busy_q, data_busy_d;
   logic [3:0]  ar_id_q;
   logic [31:0] ar_addr_q;
   logic [1:0]  ar_size_q;
   logic [31:0] aw_addr_q;
   logic [1:0]  aw_size_q;
   logic [3:0]  wstrb_q;
   logic [31:0] wdata_q;

   logic w_data_rd_acc, w_data_wr_acc, w_inst_acc;
   logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;

   // Fetch is always a read, so the instruction write flag carries no meaning.
   logic unused_inst_wr;
   assign unused_inst_wr = inst_sram_wr;

   // Accept decisions: loads wait for the write path to drain, data beats inst.
   always_comb begin
      w_data_rd_acc = ~reset & data_sram_req & ~data_sram_wr & ~data_busy_q
                      & (rd_state_q == R_IDLE) & (wr_state_q == W_IDLE);
      w_data_wr_acc = ~reset & data_sram_req & data_sram_wr & ~data_busy_q
                      & (wr_state_q == W_IDLE);
      w_inst_acc    = ~reset & inst_sram_req & ~inst_busy_q
                      & (rd_state_q == R_IDLE) & ~w_data_rd_acc;
   end

   assign w_ar_hs = arvalid & arready;
   assign w_r_hs  = rvalid & rready;
   assign w_aw_hs = awvalid & awready;
   assign w_w_hs  = wvalid & wready;
   assign w_b_hs  = bvalid & bready;

   assign inst_sram_addr_ok = w_inst_acc;
   assign data_sram_addr_ok = w_data_rd_acc | w_data_wr_acc;
   assign inst_sram_data_ok = w_r_hs & (rid == INST_ID);
   assign data_sram_data_ok = (w_r_hs & (rid == DATA_ID)) | w_b_hs;
   assign inst_sram_rdata   = rdata;
   assign data_sram_rdata   = rdata;

   assign arid    = ar_id_q;
   assign araddr  = ar_addr_q;
   assign arsize  = {1'b0, ar_size_q};
   assign arvalid = (rd_state_q == R_AR);
   assign rready  = (rd_state_q == R_R);
   assign awid    = DATA_ID;
   assign awaddr  = aw_addr_q;
   assign awsize  = {1'b0, aw_size_q};
   assign awvalid = (wr_state_q == W_REQ) & ~aw_done_q;
   assign wid     = DATA_ID;
   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign wlast   = 1'b1;
   assign wvalid  = (wr_state_q == W_REQ) & ~w_done_q;
   assign bready  = (wr_state_q == W_B);

   assign arlen   = 4'd0;
   assign awlen   = 4'd0;
   assign arburst = 2'b01;
   assign awburst = 2'b01;
   assign arlock  = 2'd0;
   assign awlock  = 2'd0;
   assign arcache = 4'd0;
   assign awcache = 4'd0;
   assign arprot  = 3'd0;
   assign awprot  = 3'd0;

   // Next state of both channel FSMs, the AW/W done flags and port busy flags.
   always_comb begin
      rd_state_d  = rd_state_q;
      wr_state_d  = wr_state_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      inst_busy_d = inst_busy_q;
      data_busy_d = data_busy_q;

      case (rd_state_q)
         R_IDLE:  if (w_data_rd_acc | w_inst_acc) rd_state_d = R_AR;
         R_AR:    if (w_ar_hs) rd_state_d = R_R;
         R_R:     if (w_r_hs) rd_state_d = R_IDLE;
         default: rd_state_d = R_IDLE;
      endcase

      case (wr_state_q)
         W_IDLE: if (w_data_wr_acc) wr_state_d = W_REQ;
         W_REQ: begin
            if (w_aw_hs) aw_done_d = 1'b1;
            if (w_w_hs)  w_done_d  = 1'b1;
            // AW and W may finish in either order or in the same cycle.
            if ((aw_done_q | w_aw_hs) & (w_done_q | w_w_hs)) begin
               wr_state_d = W_B;
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
            end
         end
         W_B:     if (w_b_hs) wr_state_d = W_IDLE;
         default: wr_state_d = W_IDLE;
      endcase

      if (inst_sram_addr_ok)      inst_busy_d = 1'b1;
      else if (inst_sram_data_ok) inst_busy_d = 1'b0;
      if (data_sram_addr_ok)      data_busy_d = 1'b1;
      else if (data_sram_data_ok) data_busy_d = 1'b0;
   end

   // State and flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_state_q  <= R_IDLE;
         wr_state_q  <= W_IDLE;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         inst_busy_q <= 1'b0;
         data_busy_q <= 1'b0;
      end else begin
         rd_state_q  <= rd_state_d;
         wr_state_q  <= wr_state_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         inst_busy_q <= inst_busy_d;
         data_busy_q <= data_busy_d;
      end
   end

   // Request latch: channel payloads stay stable regardless of the CPU inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ar_id_q   <= 4'd0;
         ar_addr_q <= 32'd0;
         ar_size_q <= 2'd0;
         aw_addr_q <= 32'd0;
         aw_size_q <= 2'd0;
         wstrb_q   <= 4'd0;
         wdata_q   <= 32'd0;
      end else begin
         if (w_data_rd_acc) begin
            ar_id_q   <= DATA_ID;
            ar_addr_q <= data_sram_addr;
            ar_size_q <= data_sram_size;
         end else if (w_inst_acc) begin
            ar_id_q   <= INST_ID;
            ar_addr_q <= inst_sram_addr;
            ar_size_q <= inst_sram_size;
         end
         if (w_data_wr_acc) begin
            aw_addr_q <= data_sram_addr;
            aw_size_q <= data_sram_size;
            wstrb_q   <= data_sram_wstrb;
            wdata_q   <= data_sram_wdata;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
- Sits directly downstream of the CPU core top level and consumes its instruction and data memory requests.
- Converts two sram-like request/response ports (req/addr_ok/data_ok) into one AXI3 master interface with a single read path and a single write path.
- Handles arbitration between ports, AXI handshakes and response routing.
- Non-burst only: every transfer is a single beat.

Parameters:
- INST_ID, 4'd0, ARID used for instruction fetches; also identifies returning R beats.
- DATA_ID, 4'd1, ARID/AWID/WID used for data accesses.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- inst_sram_req / inst_sram_wr  in  1/1  fetch request; wr is ignored (fetch is always a read)
- inst_sram_size  in  2  log2 bytes
- inst_sram_addr  in  32  fetch address
- inst_sram_addr_ok / inst_sram_data_ok  out  1/1  request accepted / response valid
- inst_sram_rdata  out  32  fetch data
- data_sram_req / data_sram_wr  in  1/1  data request; 1 = store
- data_sram_size  in  2  log2 bytes
- data_sram_wstrb  in  4  byte strobes
- data_sram_addr / data_sram_wdata  in  32/32  address / store data
- data_sram_addr_ok / data_sram_data_ok  out  1/1  request accepted / response valid
- data_sram_rdata  out  32  load data
- arid/araddr/arsize/arvalid  out  4/32/3/1  read address channel; arready in 1
- rid/rdata/rvalid  in  4/32/1  read data channel; rready out 1
- awid/awaddr/awsize/awvalid  out  4/32/3/1  write address channel; awready in 1
- wid/wdata/wstrb/wvalid/wlast  out  4/32/4/1/1  write data channel; wready in 1
- bvalid  in  1  write response; bready out 1
- arlen/awlen, arburst/awburst, arlock/awlock, arcache/awcache, arprot/awprot  out  constants 0, 2'b01, 0, 0, 0

Behaviour:
- Read FSM states:
  - R_IDLE -> R_AR on read accept.
  - R_AR -> R_R on arvalid&arready.
  - R_R -> R_IDLE on rvalid&rready.
- Write FSM states:
  - W_IDLE -> W_REQ on store accept.
  - W_REQ: AW and W handshakes are tracked by independent done flags and may complete in either order or together; moves to W_B when both are done.
  - W_B -> W_IDLE on bvalid&bready.
- Outstanding limit: at most one transaction per port.
  - inst port is busy from its addr_ok until its data_ok.
  - data port is busy from its addr_ok until its data_ok.
- Accept rules (addr_ok is combinational in the accept cycle):
  - Data read: data_sram_req & ~wr & data port free & read FSM in R_IDLE & write FSM in W_IDLE. Loads wait behind stores (RAW safety).
  - Data write: data_sram_req & wr & data port free & write FSM in W_IDLE.
  - Inst read: inst_sram_req & inst port free & read FSM in R_IDLE & no data read accepted in the same cycle. Data has priority.
- Request latch: on accept, id, addr, size, wstrb and wdata are registered.
- Channel signalling:
  - arvalid is high in R_AR; arsize={1'b0,size}.
  - awvalid/wvalid are high in W_REQ until their own handshake; wlast=1.
  - rready=1 in R_R; bready=1 in W_B.
  - All valids hold stable until their handshake, independent of CPU-side inputs.
- Responses (combinational, zero added latency):
  - inst_sram_data_ok = rvalid&rready&(rid==INST_ID).
  - data_sram_data_ok = (rvalid&rready&(rid==DATA_ID)) | (bvalid&bready).
  - Both rdata outputs equal rdata.
  - A read response and a write response for the data port in the same cycle cannot occur, because only one data transaction is outstanding.
- Reset (async, any state, including mid-transaction):
  - Both FSMs go to IDLE; all valids, readies, addr_ok and data_ok are 0; latched registers are 0.
  - In-flight AXI transactions are abandoned; the slave is reset together with the bridge.

Test Plan:
- Data load: data req, wr=0, addr 0x1c000100, size 2 -> addr_ok same cycle; next cycle arvalid=1, arid=1, arsize=3'b010; slave returns rdata 0xdeadbeef, rid=1 -> data_sram_data_ok=1, data_sram_rdata=0xdeadbeef in the same cycle.
- Store, W before AW: addr 0x80, wdata 0x12345678, wstrb 4'b0011; hold awready=0 for 3 cycles while wready=1 -> wvalid drops after W handshake, awvalid holds until accepted, data_ok exactly on the bvalid cycle.
- Arbitration: inst and data loads raised in the same cycle with the read FSM idle -> only data_addr_ok=1; inst_addr_ok=1 in the first R_IDLE cycle after the data R beat.
- RAW block: store outstanding (bvalid delayed 5 cycles), then a data load -> load addr_ok stays 0 until the cycle after B completes; no arvalid before then.
- Backpressure: arready=0 for 4 cycles -> araddr/arid/arvalid remain constant; no new addr_ok on either port.
- Reset asserted in R_R with rvalid low -> arvalid/awvalid/wvalid/rready/bready/addr_ok all 0 immediately; first request after reset is accepted normally.
